mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage RV32I core, between EX and WB.
//  - Executes loads/stores over a req/ack data bus and aligns load data.
//  - Owns the MEM/WB pipeline register that drives the write-back stage.
//  - Forwards CSR write requests and PC to write-back.
//  - Requests a pipeline stall while a bus transaction is outstanding.
// PARAMETERS
//  XLEN        32  datapath / address width
//  REG_ADDR_W  5   register-file address width
//  CSR_ADDR_W  12  CSR address width
// PORTS
//  clk               in   1           core clock
//  rst               in   1           asynchronous reset, active-high
//  ex_valid          in   1           EX presents a valid instruction
//  ex_result         in   XLEN        ALU result; effective address for load/store
//  ex_store_data     in   XLEN        rs2 value for stores
//  ex_mem_op         in   4           0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU,
//                                     1000 SB, 1001 SH, 1010 SW; any other code = NONE
//  ex_wr_bck_en      in   1           register write enable
//  ex_wr_reg_addr    in   REG_ADDR_W  destination register
//  ex_pc             in   XLEN        instruction PC
//  ex_csr_wr_en/addr/data in 1/CSR_ADDR_W/XLEN  CSR write request
//  flush             in   1           discard the instruction currently in EX/MEM
//  stall_req         out  1           hold EX and all earlier stages
//  dbus_req/we       out  1/1         bus request; write strobe
//  dbus_addr         out  XLEN        word address {addr[XLEN-1:2],2'b00}
//  dbus_be           out  4           byte enables
//  dbus_wdata        out  XLEN        store data, byte/half replicated across lanes
//  dbus_ack          in   1           transaction complete; rdata valid this cycle
//  dbus_rdata        in   XLEN        load data word
//  mem_result_o      out  XLEN        to WB mem_result_i
//  wr_bck_en_o       out  1           to WB wr_bck_en_i
//  wr_reg_addr_o     out  REG_ADDR_W  to WB wr_reg_addr_i
//  wb_pc             out  XLEN        to WB wb_pc
//  mem_wb_csr_wr_en/addr/data out 1/CSR_ADDR_W/XLEN  to WB CSR write port
// BEHAVIOUR
//  - Reset: all outputs 0; FSM goes to IDLE; any outstanding request is dropped.
//  - FSM states: IDLE and WAIT.
//  - Non-memory op, or ex_valid=0: registered into MEM/WB on the next edge (1-cycle latency).
//    When ex_valid=0, the MEM/WB register takes a bubble: wr_bck_en_o=0, csr_wr_en=0.
//  - IDLE & ex_valid & memory op & !flush:
//    - stall_req=1 combinationally.
//    - Next edge: -> WAIT; dbus_* are registered from ex_*; MEM/WB takes a bubble.
//  - WAIT:
//    - dbus_req=1 and all dbus_* stay stable until dbus_ack.
//    - stall_req=!dbus_ack; EX holds its inputs while stalled.
//    - On ack: the aligned result is registered into MEM/WB; next edge -> IDLE, dbus_req=0.
//  - Store: wr_bck_en_o=0 in the MEM/WB register.
//  - Byte enables and lane selection:
//    - SB: be=0001<<a[1:0].  SH: be=0011<<{a[1],1'b0}.  SW: be=1111.
//    - LB/LBU select the byte at a[1:0]; LH/LHU select the half at a[1]; sign or zero extend.
//  - flush:
//    - In IDLE: the instruction becomes a bubble and no request is issued.
//    - In WAIT: the transaction still completes, but its result is discarded as a bubble.
//  - ex_valid while in WAIT is ignored; EX is stalled.
//  - dbus_ack while in IDLE is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN undefined:
//    - a[0] is ignored for LH/LHU/SH; a[1:0] are ignored for LW/SW.
//  MISALIGN_TRAP_EN defined:
//    - Misaligned access (LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0) issues no request
//      and raises no stall.
//    - The MEM/WB register takes a bubble.
//    - Adds outputs mem_misalign_o (1-cycle registered pulse) and mem_bad_addr_o (XLEN, held).
// TESTING
//  - ADD result 0x1234, rd=5, wb_en=1 -> next cycle mem_result_o=0x1234, wr_reg_addr_o=5, no dbus_req.
//  - LB a=0x103, rdata=0x80FF_FF7F, ack after 3 WAIT cycles -> stall 4 cycles;
//    be=1000; mem_result_o=0xFFFF_FF80.
//  - LHU a=0x102, rdata=0xBEEF_0000 -> mem_result_o=0x0000_BEEF.
//  - SH a=0x202, data=0x1234_ABCD -> addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1, wr_bck_en_o=0.
//  - flush in WAIT for LW -> req held until ack; wr_bck_en_o=0 on completion.
//  - rst asserted in WAIT -> dbus_req=0 immediately, state IDLE, stall_req=0;
//    with MISALIGN_TRAP_EN, LW a=0x101 -> mem_misalign_o=1, mem_bad_addr_o=0x101, no dbus_req.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: req/ack data bus, load alignment, MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned accesses become bubbles and raise mem_misalign_o/mem_bad_addr_o.
module mem_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [3:0]            ex_mem_op,
  input  logic                  ex_wr_bck_en,
  input  logic [REG_ADDR_W-1:0] ex_wr_reg_addr,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic                  ex_csr_wr_en,
  input  logic [CSR_ADDR_W-1:0] ex_csr_wr_addr,
  input  logic [XLEN-1:0]       ex_csr_wr_data,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [XLEN-1:0]       dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [XLEN-1:0]       dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [XLEN-1:0]       dbus_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic                  mem_misalign_o,
  output logic [XLEN-1:0]       mem_bad_addr_o,
`endif
  output logic [XLEN-1:0]       mem_result_o,
  output logic                  wr_bck_en_o,
  output logic [REG_ADDR_W-1:0] wr_reg_addr_o,
  output logic [XLEN-1:0]       wb_pc,
  output logic                  mem_wb_csr_wr_en,
  output logic [CSR_ADDR_W-1:0] mem_wb_csr_wr_addr,
  output logic [XLEN-1:0]       mem_wb_csr_wr_data
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] access_be(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: access_be = 4'b0001 << off;
      OP_LH, OP_LHU, OP_SH: access_be = 4'b0011 << {off[1], 1'b0};
      default:              access_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [3:0] op, input logic [XLEN-1:0] d);
    case (op)
      OP_SB:   store_lanes = {(XLEN/8){d[7:0]}};
      OP_SH:   store_lanes = {(XLEN/16){d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_align(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_align = {{(XLEN-8){b[7]}}, b};
      OP_LBU:  load_align = {{(XLEN-8){1'b0}}, b};
      OP_LH:   load_align = {{(XLEN-16){h[15]}}, h};
      OP_LHU:  load_align = {{(XLEN-16){1'b0}}, h};
      default: load_align = word;
    endcase
  endfunction

  state_t state_q, state_d;

  logic                  ex_is_mem;
  logic                  mis;
  logic                  start;
  logic                  discard;

  logic                  we_q;
  logic [XLEN-1:0]       addr_q;
  logic [3:0]            be_q;
  logic [XLEN-1:0]       wdata_q;
  logic [3:0]            op_q;
  logic [1:0]            off_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wben_q;
  logic [XLEN-1:0]       pc_q;
  logic                  csr_en_q;
  logic [CSR_ADDR_W-1:0] csr_addr_q;
  logic [XLEN-1:0]       csr_data_q;
  logic                  flushed_q;

  logic [XLEN-1:0]       res_q, res_d;
  logic                  wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_pc_q, wb_pc_d;
  logic                  wb_csr_en_q, wb_csr_en_d;
  logic [CSR_ADDR_W-1:0] wb_csr_addr_q, wb_csr_addr_d;
  logic [XLEN-1:0]       wb_csr_data_q, wb_csr_data_d;

  assign ex_is_mem = is_load(ex_mem_op) || is_store(ex_mem_op);

`ifdef MISALIGN_TRAP_EN
  assign mis = (((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH)) && ex_result[0])
            || (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW)) && (ex_result[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign start   = (state_q == S_IDLE) && ex_valid && ex_is_mem && !flush && !mis;
  // A flush may arrive in any WAIT cycle, including the one carrying the ack.
  assign discard = flushed_q || flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    stall_req     = 1'b0;
    dbus_req      = 1'b0;
    res_d         = ex_result;
    wb_en_d       = 1'b0;
    wb_rd_d       = ex_wr_reg_addr;
    wb_pc_d       = ex_pc;
    wb_csr_en_d   = 1'b0;
    wb_csr_addr_d = ex_csr_wr_addr;
    wb_csr_data_d = ex_csr_wr_data;
    case (state_q)
      S_IDLE: begin
        stall_req = start && !rst;
        if (start) begin
          state_d = S_WAIT;
        end else if (ex_valid && !flush && !ex_is_mem) begin
          wb_en_d     = ex_wr_bck_en;
          wb_csr_en_d = ex_csr_wr_en;
        end
      end
      S_WAIT: begin
        dbus_req  = 1'b1;
        stall_req = !dbus_ack && !rst;
        if (dbus_ack) begin
          state_d       = S_IDLE;
          res_d         = load_align(op_q, off_q, dbus_rdata);
          wb_rd_d       = rd_q;
          wb_pc_d       = pc_q;
          wb_csr_addr_d = csr_addr_q;
          wb_csr_data_d = csr_data_q;
          wb_en_d       = wben_q && is_load(op_q) && !discard;
          wb_csr_en_d   = csr_en_q && !discard;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request and instruction context, captured when the access is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      wben_q     <= 1'b0;
      pc_q       <= '0;
      csr_en_q   <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      flushed_q  <= 1'b0;
    end else if (start) begin
      we_q       <= is_store(ex_mem_op);
      addr_q     <= {ex_result[XLEN-1:2], 2'b00};
      be_q       <= access_be(ex_mem_op, ex_result[1:0]);
      wdata_q    <= store_lanes(ex_mem_op, ex_store_data);
      op_q       <= ex_mem_op;
      off_q      <= ex_result[1:0];
      rd_q       <= ex_wr_reg_addr;
      wben_q     <= ex_wr_bck_en;
      pc_q       <= ex_pc;
      csr_en_q   <= ex_csr_wr_en;
      csr_addr_q <= ex_csr_wr_addr;
      csr_data_q <= ex_csr_wr_data;
      flushed_q  <= 1'b0;
    end else if (state_q == S_WAIT && flush) begin
      flushed_q  <= 1'b1;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q         <= '0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_pc_q       <= '0;
      wb_csr_en_q   <= 1'b0;
      wb_csr_addr_q <= '0;
      wb_csr_data_q <= '0;
    end else begin
      res_q         <= res_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_pc_q       <= wb_pc_d;
      wb_csr_en_q   <= wb_csr_en_d;
      wb_csr_addr_q <= wb_csr_addr_d;
      wb_csr_data_q <= wb_csr_data_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic            mis_q;
  logic [XLEN-1:0] bad_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q      <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      mis_q <= (state_q == S_IDLE) && ex_valid && ex_is_mem && !flush && mis;
      if ((state_q == S_IDLE) && ex_valid && ex_is_mem && !flush && mis) bad_addr_q <= ex_result;
    end
  end

  assign mem_misalign_o = mis_q;
  assign mem_bad_addr_o = bad_addr_q;
`endif

  assign dbus_we            = we_q;
  assign dbus_addr          = addr_q;
  assign dbus_be            = be_q;
  assign dbus_wdata         = wdata_q;
  assign mem_result_o       = res_q;
  assign wr_bck_en_o        = wb_en_q;
  assign wr_reg_addr_o      = wb_rd_q;
  assign wb_pc              = wb_pc_q;
  assign mem_wb_csr_wr_en   = wb_csr_en_q;
  assign mem_wb_csr_wr_addr = wb_csr_addr_q;
  assign mem_wb_csr_wr_data = wb_csr_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; define MISALIGN_TRAP_EN to also cover the misalign trap.
module tb_mem_stage;

  logic        clk, rst;
  logic        ex_valid;
  logic [31:0] ex_result, ex_store_data, ex_pc, ex_csr_wr_data;
  logic [3:0]  ex_mem_op;
  logic        ex_wr_bck_en, ex_csr_wr_en, flush;
  logic [4:0]  ex_wr_reg_addr;
  logic [11:0] ex_csr_wr_addr;
  logic        stall_req, dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic [31:0] mem_result_o, wb_pc, mem_wb_csr_wr_data;
  logic        wr_bck_en_o, mem_wb_csr_wr_en;
  logic [4:0]  wr_reg_addr_o;
  logic [11:0] mem_wb_csr_wr_addr;
`ifdef MISALIGN_TRAP_EN
  logic        mem_misalign_o;
  logic [31:0] mem_bad_addr_o;
`endif

  int checks = 0;
  int errors = 0;

  int          stall_cnt;
  logic        req_held, ack_stall;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_wr_bck_en(ex_wr_bck_en),
    .ex_wr_reg_addr(ex_wr_reg_addr), .ex_pc(ex_pc), .ex_csr_wr_en(ex_csr_wr_en),
    .ex_csr_wr_addr(ex_csr_wr_addr), .ex_csr_wr_data(ex_csr_wr_data), .flush(flush),
    .stall_req(stall_req), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
`ifdef MISALIGN_TRAP_EN
    .mem_misalign_o(mem_misalign_o), .mem_bad_addr_o(mem_bad_addr_o),
`endif
    .mem_result_o(mem_result_o), .wr_bck_en_o(wr_bck_en_o), .wr_reg_addr_o(wr_reg_addr_o),
    .wb_pc(wb_pc), .mem_wb_csr_wr_en(mem_wb_csr_wr_en), .mem_wb_csr_wr_addr(mem_wb_csr_wr_addr),
    .mem_wb_csr_wr_data(mem_wb_csr_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one memory op from EX, hold it while stalled, ack after ack_wait WAIT cycles.
  task automatic mem_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] word, input int ack_wait, input logic flush_in_wait);
    ex_valid = 1'b1; ex_mem_op = op; ex_result = a; ex_store_data = sd;
    #1;
    stall_cnt = stall_req ? 1 : 0;
    tick;
    #1;
    cap_addr = dbus_addr; cap_be = dbus_be; cap_wdata = dbus_wdata; cap_we = dbus_we;
    req_held = dbus_req;
    for (int w = 0; w < ack_wait; w++) begin
      if (stall_req) stall_cnt++;
      req_held &= dbus_req;
      if (flush_in_wait && w == 0) flush = 1'b1;
      tick;
      flush = 1'b0;
      #1;
    end
    dbus_ack = 1'b1; dbus_rdata = word;
    #1;
    ack_stall = stall_req;
    req_held &= dbus_req;
    tick;
    dbus_ack = 1'b0; ex_valid = 1'b0; ex_mem_op = 4'b0000;
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_mem_op = '0;
    ex_wr_bck_en = 1'b0; ex_wr_reg_addr = '0; ex_pc = '0; ex_csr_wr_en = 1'b0;
    ex_csr_wr_addr = '0; ex_csr_wr_data = '0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    tick; tick;
    check("rst_result", mem_result_o, 32'h0);
    check("rst_wben", {31'b0, wr_bck_en_o}, 32'h0);
    check("rst_req", {31'b0, dbus_req}, 32'h0);
    check("rst_stall", {31'b0, stall_req}, 32'h0);
    rst = 1'b0;
    tick;

    // ALU op passes through in one cycle
    ex_valid = 1'b1; ex_mem_op = 4'b0000; ex_result = 32'h1234; ex_wr_reg_addr = 5'd5;
    ex_wr_bck_en = 1'b1; ex_pc = 32'h100;
    #1;
    check("add_stall", {31'b0, stall_req}, 32'h0);
    tick;
    check("add_result", mem_result_o, 32'h1234);
    check("add_rd", {27'b0, wr_reg_addr_o}, 32'd5);
    check("add_wben", {31'b0, wr_bck_en_o}, 32'h1);
    check("add_pc", wb_pc, 32'h100);
    check("add_req", {31'b0, dbus_req}, 32'h0);

    // Bubble, with a stray ack in IDLE
    ex_valid = 1'b0; dbus_ack = 1'b1;
    tick;
    check("idle_ack_wben", {31'b0, wr_bck_en_o}, 32'h0);
    check("idle_ack_req", {31'b0, dbus_req}, 32'h0);
    dbus_ack = 1'b0;

    // CSR write forwarding on a non-memory op
    ex_valid = 1'b1; ex_wr_bck_en = 1'b0; ex_csr_wr_en = 1'b1; ex_csr_wr_addr = 12'h300;
    ex_csr_wr_data = 32'hABC; ex_pc = 32'h104;
    tick;
    check("csr_en", {31'b0, mem_wb_csr_wr_en}, 32'h1);
    check("csr_addr", {20'b0, mem_wb_csr_wr_addr}, 32'h300);
    check("csr_data", mem_wb_csr_wr_data, 32'hABC);
    ex_valid = 1'b0; ex_csr_wr_en = 1'b0;
    tick;
    check("csr_bubble", {31'b0, mem_wb_csr_wr_en}, 32'h0);

    // LB with three unacked WAIT cycles
    ex_wr_bck_en = 1'b1; ex_wr_reg_addr = 5'd3; ex_pc = 32'h108;
    mem_access(4'b0001, 32'h103, 32'h0, 32'h80FF_FF7F, 3, 1'b0);
    check("lb_stall_cycles", stall_cnt, 32'd4);
    check("lb_ack_stall", {31'b0, ack_stall}, 32'h0);
    check("lb_req_held", {31'b0, req_held}, 32'h1);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_be", {28'b0, cap_be}, 32'h8);
    check("lb_we", {31'b0, cap_we}, 32'h0);
    check("lb_result", mem_result_o, 32'hFFFF_FF80);
    check("lb_wben", {31'b0, wr_bck_en_o}, 32'h1);
    check("lb_rd", {27'b0, wr_reg_addr_o}, 32'd3);
    check("lb_pc", wb_pc, 32'h108);
    check("lb_req_after", {31'b0, dbus_req}, 32'h0);

    // LHU upper half
    ex_wr_reg_addr = 5'd4;
    mem_access(4'b0101, 32'h102, 32'h0, 32'hBEEF_0000, 0, 1'b0);
    check("lhu_be", {28'b0, cap_be}, 32'hC);
    check("lhu_result", mem_result_o, 32'h0000_BEEF);
    check("lhu_wben", {31'b0, wr_bck_en_o}, 32'h1);

    // LH sign extension of the lower half
    mem_access(4'b0010, 32'h100, 32'h0, 32'h1234_8001, 1, 1'b0);
    check("lh_result", mem_result_o, 32'hFFFF_8001);

    // SH with write-back enable asserted must still not write back
    mem_access(4'b1001, 32'h202, 32'h1234_ABCD, 32'h0, 1, 1'b0);
    check("sh_addr", cap_addr, 32'h200);
    check("sh_be", {28'b0, cap_be}, 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'b0, cap_we}, 32'h1);
    check("sh_wben", {31'b0, wr_bck_en_o}, 32'h0);

    // SB lane replication
    mem_access(4'b1000, 32'h101, 32'h0000_0055, 32'h0, 0, 1'b0);
    check("sb_be", {28'b0, cap_be}, 32'h2);
    check("sb_wdata", cap_wdata, 32'h5555_5555);

    // LW flushed while waiting: bus completes, result dropped
    ex_wr_reg_addr = 5'd7;
    mem_access(4'b0011, 32'h300, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);
    check("lwf_req_held", {31'b0, req_held}, 32'h1);
    check("lwf_wben", {31'b0, wr_bck_en_o}, 32'h0);

    // LW flushed in IDLE: no request at all
    ex_valid = 1'b1; ex_mem_op = 4'b0011; ex_result = 32'h400; flush = 1'b1;
    #1;
    check("lwi_stall", {31'b0, stall_req}, 32'h0);
    tick;
    check("lwi_req", {31'b0, dbus_req}, 32'h0);
    check("lwi_wben", {31'b0, wr_bck_en_o}, 32'h0);
    flush = 1'b0; ex_valid = 1'b0;

    // Asynchronous reset while waiting
    ex_valid = 1'b1; ex_mem_op = 4'b0011; ex_result = 32'h500;
    tick;
    check("rstw_req_before", {31'b0, dbus_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstw_req", {31'b0, dbus_req}, 32'h0);
    check("rstw_stall", {31'b0, stall_req}, 32'h0);
    ex_valid = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    check("rstw_req_after", {31'b0, dbus_req}, 32'h0);
    check("rstw_wben", {31'b0, wr_bck_en_o}, 32'h0);

`ifdef MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_mem_op = 4'b0011; ex_result = 32'h101; ex_wr_bck_en = 1'b1;
    #1;
    check("mis_stall", {31'b0, stall_req}, 32'h0);
    tick;
    check("mis_pulse", {31'b0, mem_misalign_o}, 32'h1);
    check("mis_addr", mem_bad_addr_o, 32'h101);
    check("mis_req", {31'b0, dbus_req}, 32'h0);
    check("mis_wben", {31'b0, wr_bck_en_o}, 32'h0);
    ex_valid = 1'b0;
    tick;
    check("mis_pulse_end", {31'b0, mem_misalign_o}, 32'h0);
    check("mis_addr_held", mem_bad_addr_o, 32'h101);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
